// File: rtl/collision_detect.sv
`default_nettype none
// ============================================================================
// Module      : collision_detect
// Description : Per-pixel collision arbiter. Accumulates ship/bullet/asteroid
//               overlaps over a frame, emits one-cycle hit pulses at end of
//               frame, tracks a ship invulnerability window and a score.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_detect #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int N_OBJ        = 8,
  parameter int MIN_OVERLAP  = 4,
  parameter int GRACE_FRAMES = 120
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      active,
  input  logic [$clog2(WIDTH)-1:0]  pxl_x,
  input  logic [$clog2(HEIGHT)-1:0] pxl_y,
  input  logic                      ship_draw,
  input  logic                      bullet_draw,
  input  logic [N_OBJ-1:0]          obj_draw,
  output logic                      ship_collision,
  output logic [N_OBJ-1:0]          obj_hit,
  output logic                      bullet_hit,
  output logic                      frame_done,
  output logic                      invulnerable,
  output logic [15:0]               score
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  // Overlap counter only needs to reach MIN_OVERLAP, where it saturates.
  localparam int CW = (MIN_OVERLAP > 0) ? $clog2(MIN_OVERLAP + 1) : 1;
  // Grace counter holds values 0 .. GRACE_FRAMES-1.
  localparam int GW = (GRACE_FRAMES > 1) ? $clog2(GRACE_FRAMES) : 1;

  typedef enum logic [0:0] {
    ARMED = 1'b0,
    GRACE = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [GW-1:0]     grace_cnt;
  logic [GW-1:0]     grace_cnt_next;

  logic [CW-1:0]     ovl_cnt;
  logic [CW-1:0]     ovl_cnt_next;
  logic [N_OBJ-1:0]  obj_acc;
  logic [N_OBJ-1:0]  obj_acc_next;
  logic              bullet_acc;
  logic              bullet_acc_next;

  logic              any_obj;
  logic              end_of_frame;
  logic              ship_hit_now;
  logic [16:0]       score_sum;

  function automatic logic [16:0] popcount(input logic [N_OBJ-1:0] v);
    logic [16:0] n;
    n = 17'd0;
    for (int i = 0; i < N_OBJ; i++) begin
      n = n + 17'(v[i]);
    end
    return n;
  endfunction

  // Fold the current pixel into the frame accumulators; flag the end pixel.
  always_comb begin
    any_obj      = |obj_draw;
    ovl_cnt_next = ovl_cnt;
    if (active && ship_draw && any_obj && (ovl_cnt < CW'(MIN_OVERLAP))) begin
      ovl_cnt_next = ovl_cnt + CW'(1);
    end
    obj_acc_next    = obj_acc | (obj_draw & {N_OBJ{active & (bullet_draw | ship_draw)}});
    bullet_acc_next = bullet_acc | (active & bullet_draw & any_obj);
    end_of_frame    = active && (pxl_x == XW'(WIDTH - 1)) && (pxl_y == YW'(HEIGHT - 1));
    // A pulse still in flight means GRACE is about to be entered; do not
    // report the ship twice if end pixels arrive back to back.
    ship_hit_now    = (ovl_cnt_next >= CW'(MIN_OVERLAP)) && (state == ARMED) && !ship_collision;
    score_sum       = {1'b0, score} + popcount(obj_hit);
  end

  // Frame accumulators and end-of-frame pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovl_cnt        <= '0;
      obj_acc        <= '0;
      bullet_acc     <= 1'b0;
      frame_done     <= 1'b0;
      ship_collision <= 1'b0;
      obj_hit        <= '0;
      bullet_hit     <= 1'b0;
    end else if (end_of_frame) begin
      ovl_cnt        <= '0;
      obj_acc        <= '0;
      bullet_acc     <= 1'b0;
      frame_done     <= 1'b1;
      ship_collision <= ship_hit_now;
      obj_hit        <= obj_acc_next;
      bullet_hit     <= bullet_acc_next;
    end else begin
      ovl_cnt        <= ovl_cnt_next;
      obj_acc        <= obj_acc_next;
      bullet_acc     <= bullet_acc_next;
      frame_done     <= 1'b0;
      ship_collision <= 1'b0;
      obj_hit        <= '0;
      bullet_hit     <= 1'b0;
    end
  end

  // Score accumulates the asteroid hits reported in the current pulse cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score <= 16'd0;
    end else if (frame_done) begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end

  // Invulnerability state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARMED;
      grace_cnt <= '0;
    end else begin
      state     <= state_next;
      grace_cnt <= grace_cnt_next;
    end
  end

  // Next-state: enter GRACE after a ship hit, count frames down, re-arm.
  always_comb begin
    state_next     = state;
    grace_cnt_next = grace_cnt;
    case (state)
      ARMED: begin
        if (ship_collision && (GRACE_FRAMES > 0)) begin
          state_next     = GRACE;
          grace_cnt_next = GW'(GRACE_FRAMES - 1);
        end
      end
      GRACE: begin
        if (frame_done) begin
          if (grace_cnt == '0) begin
            state_next = ARMED;
          end else begin
            grace_cnt_next = grace_cnt - GW'(1);
          end
        end
      end
      default: state_next = ARMED;
    endcase
  end

  assign invulnerable = (state == GRACE);

endmodule
`default_nettype wire
